issue_queue_scheduler: RTL and testbench

//   Allocation and issue control for a bank of NUM_SLOTS capped issue entries feeding one functional unit.
//   - Steers each dispatched renamed op into a free slot.
//   - Picks one wakeup-ready slot per cycle and drains it into a registered issue stage toward the FU.
//   - Sits between rename/dispatch and the FU; the slots themselves are instantiated alongside, not inside.

---
 rtl/issue_queue_scheduler_pkg.sv | 28 ++
 rtl/issue_queue_scheduler_if.sv | 51 +++++
 rtl/issue_queue_scheduler_age_matrix.sv | 52 +++++
 rtl/issue_queue_scheduler.sv | 122 ++++++++++++
 tb/tb_issue_queue_scheduler.sv | 387 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/issue_queue_scheduler_pkg.sv
// Shared sizes and helpers for the issue queue scheduler.
// Renamed-op width comes from RENAMED_OP_SZ.
`ifndef RENAMED_OP_SZ
`define RENAMED_OP_SZ 16
`endif

package issue_queue_scheduler_pkg;

  localparam int OP_SZ = `RENAMED_OP_SZ;

  function automatic logic [31:0] lowest_one(
    input logic [31:0] v
  );
    return v & (~v + 32'd1);
  endfunction

  function automatic int unsigned popcount(
    input logic [31:0] v
  );
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/issue_queue_scheduler_if.sv
// Dispatch, slot and FU-issue bundle of the scheduler.
// slave = scheduler side, master = surrounding logic.
interface issue_queue_scheduler_if #(
  parameter int INST_WIDTH = 16,
  parameter int NUM_SLOTS  = 4
);

  logic [INST_WIDTH-1:0]           disp_instr;
  logic                            disp_valid;
  logic                            disp_ready;
  logic [INST_WIDTH-1:0]           slot_instr;
  logic [NUM_SLOTS-1:0]            slot_input_valid;
  logic [NUM_SLOTS-1:0]            slot_input_ready;
  logic [NUM_SLOTS-1:0]            slot_output_valid;
  logic [NUM_SLOTS*INST_WIDTH-1:0] slot_instr_out;
  logic [NUM_SLOTS-1:0]            slot_output_ready;
  logic [INST_WIDTH-1:0]           issue_instr;
  logic                            issue_valid;
  logic                            issue_ready;

  modport slave (
    input  disp_instr,
    input  disp_valid,
    output disp_ready,
    output slot_instr,
    output slot_input_valid,
    input  slot_input_ready,
    input  slot_output_valid,
    input  slot_instr_out,
    output slot_output_ready,
    output issue_instr,
    output issue_valid,
    input  issue_ready
  );

  modport master (
    output disp_instr,
    output disp_valid,
    input  disp_ready,
    input  slot_instr,
    input  slot_input_valid,
    output slot_input_ready,
    output slot_output_valid,
    output slot_instr_out,
    input  slot_output_ready,
    input  issue_instr,
    input  issue_valid,
    output issue_ready
  );

endinterface

// File: rtl/issue_queue_scheduler_age_matrix.sv
// Age matrix with oldest-ready select (module issue_age_matrix).
// Only built when ISSUE_AGE_ORDER_EN is defined.
`ifdef ISSUE_AGE_ORDER_EN
module issue_age_matrix #(
  parameter int NUM_SLOTS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_SLOTS-1:0] occ,
  input  logic [NUM_SLOTS-1:0] alloc,
  input  logic [NUM_SLOTS-1:0] ready,
  output logic [NUM_SLOTS-1:0] grant
);

  logic [NUM_SLOTS-1:0][NUM_SLOTS-1:0] older_q;
  logic [NUM_SLOTS-1:0][NUM_SLOTS-1:0] older_d;
  logic                                blocked;

  // new entry is younger than every occupied slot
  always_comb begin
    older_d = older_q;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (alloc[i]) begin
        older_d[i] = '0;
        for (int j = 0; j < NUM_SLOTS; j++) begin
          older_d[j][i] = occ[j] && (j != i);
        end
      end
    end
  end

  // grant the ready slot that no other ready slot predates
  always_comb begin
    grant   = '0;
    blocked = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      blocked = 1'b0;
      for (int j = 0; j < NUM_SLOTS; j++) begin
        if (ready[j] && older_q[j][i]) blocked = 1'b1;
      end
      grant[i] = ready[i] && !blocked;
    end
  end

  // age matrix register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) older_q <= '0;
    else        older_q <= older_d;
  end

endmodule
`endif

// File: rtl/issue_queue_scheduler.sv
// Issue slot allocation, select and 1-entry issue register.
// ISSUE_AGE_ORDER_EN: oldest-first select, else round-robin.
module issue_queue_scheduler
  import issue_queue_scheduler_pkg::*;
#(
  parameter int INST_WIDTH = OP_SZ,
  parameter int NUM_SLOTS  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  issue_queue_scheduler_if.slave         bus,
  output logic [$clog2(NUM_SLOTS+1)-1:0] occupancy
);

  localparam int CW = $clog2(NUM_SLOTS + 1);

  logic [NUM_SLOTS-1:0]  occ_q, occ_d;
  logic [NUM_SLOTS-1:0]  alloc_oh;
  logic [NUM_SLOTS-1:0]  cand;
  logic [NUM_SLOTS-1:0]  grant;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  iv_q, iv_d;
  logic [INST_WIDTH-1:0] ii_q, ii_d;
  logic [INST_WIDTH-1:0] sel_op;
  logic                  advance;

  // steer dispatch into the lowest-index empty slot
  always_comb begin
    alloc_oh = '0;
    if (bus.disp_valid) begin
      alloc_oh = NUM_SLOTS'(lowest_one(32'(bus.slot_input_ready)));
    end
  end

  assign bus.disp_ready        = |bus.slot_input_ready;
  assign bus.slot_instr        = bus.disp_instr;
  assign bus.slot_input_valid  = alloc_oh;
  assign advance               = !iv_q || bus.issue_ready;
  assign cand                  = bus.slot_output_valid & {NUM_SLOTS{advance}};
  assign bus.slot_output_ready = grant;
  assign bus.issue_valid       = iv_q;
  assign bus.issue_instr       = ii_q;
  assign occupancy             = cnt_q;

`ifdef ISSUE_AGE_ORDER_EN
  issue_age_matrix #(
    .NUM_SLOTS (NUM_SLOTS)
  ) u_age (
    .clk   (clk),
    .rst_n (rst),
    .occ   (occ_q),
    .alloc (alloc_oh),
    .ready (cand),
    .grant (grant)
  );
`else
  localparam int PW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  logic [PW-1:0] rr_q, rr_d;
  logic          found;

  // rotate search from rr pointer; pointer moves past the winner
  always_comb begin
    grant = '0;
    found = 1'b0;
    rr_d  = rr_q;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (!found && cand[(int'(rr_q) + k) % NUM_SLOTS]) begin
        grant[(int'(rr_q) + k) % NUM_SLOTS] = 1'b1;
        rr_d  = PW'((int'(rr_q) + k + 1) % NUM_SLOTS);
        found = 1'b1;
      end
    end
  end

  // round-robin pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rr_q <= '0;
    else      rr_q <= rr_d;
  end
`endif

  // mux the granted slot's op
  always_comb begin
    sel_op = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (grant[i]) sel_op |= bus.slot_instr_out[i*INST_WIDTH +: INST_WIDTH];
    end
  end

  // issue register loads on advance, holds under backpressure
  always_comb begin
    iv_d = iv_q;
    ii_d = ii_q;
    if (advance) begin
      iv_d = |grant;
      if (|grant) ii_d = sel_op;
    end
  end

  // occupancy bits and their registered count
  always_comb begin
    occ_d = (occ_q | alloc_oh) & ~grant;
    cnt_d = CW'(popcount(32'(occ_d)));
  end

  // state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q <= '0;
      cnt_q <= '0;
      iv_q  <= 1'b0;
      ii_q  <= '0;
    end else begin
      occ_q <= occ_d;
      cnt_q <= cnt_d;
      iv_q  <= iv_d;
      ii_q  <= ii_d;
    end
  end

endmodule

// File: tb/tb_issue_queue_scheduler.sv
// Self-checking bench for issue_queue_scheduler with a
// behavioural 4-slot bank and an issue scoreboard.
module tb_issue_queue_scheduler;
  import issue_queue_scheduler_pkg::*;

  localparam int W  = OP_SZ;
  localparam int NS = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   occupancy;
  logic [NS-1:0] full, rdy, avail;
  logic [W-1:0] op [NS];
  logic [W-1:0] exp_q [$];
  logic [W-1:0] e;
  int           errors = 0;
  int           checks = 0;

  always #5 clk = ~clk;

  issue_queue_scheduler_if #(.INST_WIDTH(W), .NUM_SLOTS(NS)) bus ();

  issue_queue_scheduler #(
    .INST_WIDTH (W),
    .NUM_SLOTS  (NS)
  ) dut (
    .clk       (clk),
    .rst       (rst_n),
    .bus       (bus),
    .occupancy (occupancy)
  );

  // slot bank model sharing reset with the scheduler
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= '0;
    end else begin
      for (int i = 0; i < NS; i++) begin
        if (bus.slot_input_valid[i]) begin
          full[i] <= 1'b1;
          op[i]   <= bus.slot_instr;
        end else if (bus.slot_output_ready[i]) begin
          full[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.slot_input_ready  = ~full & avail;
  assign bus.slot_output_valid = full & rdy;

  for (genvar g = 0; g < NS; g++) begin : g_pack
    assign bus.slot_instr_out[g*W +: W] = op[g];
  end

  task test_reset;
    @(negedge clk);
    checks++;
    if (bus.issue_valid !== 1'b0) begin
      errors++; $display("FAIL rst_valid got %b want 0", bus.issue_valid);
    end
    checks++;
    if (bus.issue_instr !== '0) begin
      errors++; $display("FAIL rst_instr got %h want 0", bus.issue_instr);
    end
    checks++;
    if (occupancy !== 3'd0) begin
      errors++; $display("FAIL rst_occ got %0d want 0", occupancy);
    end
    checks++;
    if (bus.disp_ready !== 1'b1) begin
      errors++; $display("FAIL rst_disp_ready got %b want 1", bus.disp_ready);
    end
    rst_n = 1'b1;
  endtask

  task test_alloc;
    for (int k = 0; k < 3; k++) begin
      bus.disp_valid = 1'b1;
      bus.disp_instr = W'(16'hA000 + k);
      #1;
      checks++;
      if (bus.slot_input_valid !== 4'(1 << k)) begin
        errors++;
        $display("FAIL alloc_%0d got %b want %b", k, bus.slot_input_valid, 4'(1 << k));
      end
      @(negedge clk);
    end
    bus.disp_valid = 1'b0;
    #1;
    checks++;
    if (occupancy !== 3'd3) begin
      errors++; $display("FAIL alloc_occ got %0d want 3", occupancy);
    end
  endtask

  task test_drain_all;
    int nv, first, last;
    bus.disp_valid = 1'b1;
    bus.disp_instr = W'(16'hA003);
    #1;
    checks++;
    if (bus.slot_input_valid !== 4'b1000) begin
      errors++; $display("FAIL alloc_3 got %b want 1000", bus.slot_input_valid);
    end
    @(negedge clk);
    bus.disp_instr = W'(16'hA004);
    #1;
    checks++;
    if (bus.disp_ready !== 1'b0 || bus.slot_input_valid !== 4'b0000) begin
      errors++;
      $display("FAIL full_block got rdy=%b siv=%b want 0/0000",
               bus.disp_ready, bus.slot_input_valid);
    end
    checks++;
    if (occupancy !== 3'd4) begin
      errors++; $display("FAIL full_occ got %0d want 4", occupancy);
    end
    bus.disp_valid  = 1'b0;
    bus.issue_ready = 1'b1;
    rdy = 4'hF;
    for (int k = 0; k < 4; k++) exp_q.push_back(W'(16'hA000 + k));
    #1;
    checks++;
    if (bus.slot_output_ready !== 4'b0001) begin
      errors++; $display("FAIL drain_first_grant got %b want 0001", bus.slot_output_ready);
    end
    nv = 0; first = -1; last = -1;
    for (int c = 0; c < 10; c++) begin
      if (bus.issue_valid && bus.issue_ready) begin
        nv++;
        if (first < 0) first = c;
        last = c;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL drain_extra got %h want none", bus.issue_instr);
        end else begin
          e = exp_q.pop_front();
          if (bus.issue_instr !== e) begin
            errors++; $display("FAIL drain_op got %h want %h", bus.issue_instr, e);
          end
        end
      end
      @(negedge clk);
    end
    checks++;
    if (nv != 4 || last - first != 3) begin
      errors++; $display("FAIL drain_count got %0d span %0d want 4 span 3", nv, last - first);
    end
    checks++;
    if (exp_q.size() != 0 || occupancy !== 3'd0) begin
      errors++;
      $display("FAIL drain_end got left=%0d occ=%0d want 0/0", exp_q.size(), occupancy);
    end
    rdy = 4'h0;
  endtask

  task test_order;
    int nv;
    avail = 4'b0100;
    bus.disp_valid = 1'b1;
    bus.disp_instr = W'(16'hB002);
    @(negedge clk);
    avail = 4'b0001;
    bus.disp_instr = W'(16'hB000);
    @(negedge clk);
    bus.disp_valid = 1'b0;
    avail = 4'hF;
    rdy = 4'b0101;
`ifdef ISSUE_AGE_ORDER_EN
    exp_q.push_back(W'(16'hB002));
    exp_q.push_back(W'(16'hB000));
    e = W'(16'h0004);
`else
    exp_q.push_back(W'(16'hB000));
    exp_q.push_back(W'(16'hB002));
    e = W'(16'h0001);
`endif
    #1;
    checks++;
    if (bus.slot_output_ready !== e[NS-1:0]) begin
      errors++; $display("FAIL order_grant got %b want %b", bus.slot_output_ready, e[NS-1:0]);
    end
    nv = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.issue_valid && bus.issue_ready) begin
        nv++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL order_extra got %h want none", bus.issue_instr);
        end else begin
          e = exp_q.pop_front();
          if (bus.issue_instr !== e) begin
            errors++; $display("FAIL order_op got %h want %h", bus.issue_instr, e);
          end
        end
      end
      @(negedge clk);
    end
    checks++;
    if (nv != 2 || exp_q.size() != 0) begin
      errors++; $display("FAIL order_count got %0d want 2", nv);
    end
    rdy = 4'h0;
  endtask

  task test_backpressure;
    int nv;
    bus.issue_ready = 1'b0;
    bus.disp_valid  = 1'b1;
    bus.disp_instr  = W'(16'hC000);
    @(negedge clk);
    bus.disp_instr  = W'(16'hC001);
    @(negedge clk);
    bus.disp_valid  = 1'b0;
    rdy = 4'b0011;
    exp_q.push_back(W'(16'hC000));
    exp_q.push_back(W'(16'hC001));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus.issue_valid !== 1'b1 || bus.issue_instr !== exp_q[0]
          || bus.slot_output_ready !== 4'b0000) begin
        errors++;
        $display("FAIL bp_hold_%0d got v=%b op=%h gnt=%b want 1/%h/0000",
                 c, bus.issue_valid, bus.issue_instr, bus.slot_output_ready, exp_q[0]);
      end
    end
    bus.issue_ready = 1'b1;
    nv = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.issue_valid && bus.issue_ready) begin
        nv++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL bp_extra got %h want none", bus.issue_instr);
        end else begin
          e = exp_q.pop_front();
          if (bus.issue_instr !== e) begin
            errors++; $display("FAIL bp_op got %h want %h", bus.issue_instr, e);
          end
        end
      end
      @(negedge clk);
    end
    checks++;
    if (nv != 2 || exp_q.size() != 0) begin
      errors++; $display("FAIL bp_count got %0d want 2", nv);
    end
    rdy = 4'h0;
  endtask

  task test_full_refill;
    for (int k = 0; k < 4; k++) begin
      bus.disp_valid = 1'b1;
      bus.disp_instr = W'(16'hD000 + k);
      @(negedge clk);
    end
    bus.disp_instr = W'(16'hD00A);
    #1;
    checks++;
    if (bus.disp_ready !== 1'b0 || bus.slot_input_valid !== 4'b0000
        || occupancy !== 3'd4) begin
      errors++;
      $display("FAIL refill_full got rdy=%b siv=%b occ=%0d want 0/0000/4",
               bus.disp_ready, bus.slot_input_valid, occupancy);
    end
    rdy = 4'b0010;
    exp_q.push_back(W'(16'hD001));
    #1;
    checks++;
    if (bus.slot_output_ready !== 4'b0010) begin
      errors++; $display("FAIL refill_gnt1 got %b want 0010", bus.slot_output_ready);
    end
    @(negedge clk);
    rdy = 4'b0000;
    e = exp_q.pop_front();
    checks++;
    if (bus.issue_valid !== 1'b1 || bus.issue_instr !== e) begin
      errors++; $display("FAIL refill_op1 got %b/%h want 1/%h", bus.issue_valid, bus.issue_instr, e);
    end
    #1;
    checks++;
    if (bus.slot_input_valid !== 4'b0010 || occupancy !== 3'd3) begin
      errors++;
      $display("FAIL refill_alloc1 got siv=%b occ=%0d want 0010/3", bus.slot_input_valid, occupancy);
    end
    @(negedge clk);
    checks++;
    if (occupancy !== 3'd4) begin
      errors++; $display("FAIL refill_occ got %0d want 4", occupancy);
    end
    bus.disp_instr = W'(16'hD00B);
    rdy = 4'b0100;
    exp_q.push_back(W'(16'hD002));
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (bus.issue_instr !== e) begin
      errors++; $display("FAIL refill_op2 got %h want %h", bus.issue_instr, e);
    end
    rdy = 4'b0001;
    exp_q.push_back(W'(16'hD000));
    #1;
    checks++;
    if (bus.slot_input_valid !== 4'b0100 || bus.slot_output_ready !== 4'b0001
        || occupancy !== 3'd3) begin
      errors++;
      $display("FAIL simul_ag got siv=%b gnt=%b occ=%0d want 0100/0001/3",
               bus.slot_input_valid, bus.slot_output_ready, occupancy);
    end
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (bus.issue_instr !== e) begin
      errors++; $display("FAIL refill_op0 got %h want %h", bus.issue_instr, e);
    end
    rdy = 4'b0000;
    bus.disp_valid = 1'b0;
    #1;
    checks++;
    if (occupancy !== 3'd3) begin
      errors++; $display("FAIL simul_occ got %0d want 3", occupancy);
    end
  endtask

  task test_reset_mid;
    @(negedge clk);
    bus.issue_ready = 1'b0;
    rdy = 4'hF;
    @(negedge clk);
    checks++;
    if (bus.issue_valid !== 1'b1) begin
      errors++; $display("FAIL mid_pre_valid got %b want 1", bus.issue_valid);
    end
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if (bus.issue_valid !== 1'b0 || occupancy !== 3'd0 || bus.issue_instr !== '0) begin
      errors++;
      $display("FAIL mid_rst got v=%b occ=%0d op=%h want 0/0/0",
               bus.issue_valid, occupancy, bus.issue_instr);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (bus.slot_output_ready !== 4'b0000 || bus.issue_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_hold_%0d got gnt=%b v=%b want 0000/0",
                 c, bus.slot_output_ready, bus.issue_valid);
      end
    end
    rst_n = 1'b1;
    rdy = 4'h0;
    #1;
    checks++;
    if (bus.disp_ready !== 1'b1 || occupancy !== 3'd0) begin
      errors++;
      $display("FAIL mid_after got rdy=%b occ=%0d want 1/0", bus.disp_ready, occupancy);
    end
    @(negedge clk);
    checks++;
    if (bus.issue_valid !== 1'b0) begin
      errors++; $display("FAIL mid_after_valid got %b want 0", bus.issue_valid);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.disp_valid  = 1'b0;
    bus.disp_instr  = '0;
    bus.issue_ready = 1'b0;
    rdy   = 4'h0;
    avail = 4'hF;
    test_reset();
    test_alloc();
    test_drain_all();
    test_order();
    test_backpressure();
    test_full_refill();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
